// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-wide little-endian data memory.
// Each request becomes 1, 2 or 4 byte beats followed by a one-cycle response pulse.
module mem_access_unit #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        beat_q, beat_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic [1:0]        last_beat;
  logic [31:0]       loaded;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    logic [31:0] ext;
    case (size)
      2'b00:   ext = {{24{~uns & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{~uns & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  always_comb begin
    case (size_q)
      2'b00:   last_beat = 2'd0;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  end

  // Current data register with the byte arriving on this beat merged in.
  always_comb begin
    loaded = data_q;
    loaded[{beat_q, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    beat_d       = beat_q;
    to_cnt_d     = to_cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          wdata_d     = req_wdata;
          data_d      = '0;
          beat_d      = '0;
          to_cnt_d    = '0;
          req_ready_d = 1'b0;
          mem_addr_d  = req_addr[ADDR_W-1:0];
          mem_wdata_d = req_wdata[7:0];
          if (req_size == 2'b11) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d  = BEAT;
            mem_re_d = ~req_write;
            mem_we_d = req_write;
          end
        end
      end

      BEAT: begin
        if (mem_ack) begin
          to_cnt_d = '0;
          if (!write_q) data_d = loaded;
          if (beat_q == last_beat) begin
            state_d      = RESP;
            mem_re_d     = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = write_q ? 32'h0 : extend(loaded, size_q, unsigned_q);
          end else begin
            beat_d      = beat_q + 2'd1;
            mem_addr_d  = mem_addr_q + 1'b1;
            wdata_d     = wdata_q >> 8;
            mem_wdata_d = wdata_q[15:8];
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Bytes already stored stay in memory; only the response reports the abort.
          state_d      = RESP;
          mem_re_d     = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      data_q       <= '0;
      beat_q       <= '0;
      to_cnt_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      beat_q       <= beat_d;
      to_cnt_q     <= to_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array memory responder with programmable ack delay,
// and a reference model that computes load/store results and timing from plain arithmetic.
module tb_mem_access_unit;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] dut_mem [DEPTH];
  int         ack_delay = 0;
  bit         ack_never = 1'b0;
  int         wait_cnt;
  int         n_compared = 0;
  int         n_mismatched = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  assign mem_ack   = (mem_re | mem_we) && !ack_never && (wait_cnt >= ack_delay);
  assign mem_rdata = dut_mem[mem_addr];

  // Memory responder; reset reloads its contents from the model so both stay in step.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt = 0;
      for (int k = 0; k < DEPTH; k++) dut_mem[k] = ref_mem[k];
    end else if (mem_re | mem_we) begin
      if (mem_ack) begin
        if (mem_we) dut_mem[mem_addr] = mem_wdata;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Little-endian gather followed by two's-complement reinterpretation.
  function automatic logic [31:0] model_load(input int base, input logic [1:0] sz, input bit uns);
    int     n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_mem[(base + k) % DEPTH]) << (8 * k);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int delay, input bit never);
    int                n, exp_lat, exp_beats, cycles;
    bit                got, v_ready, v_both, v_hold, v_dir, waiting;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W-1:0] beats[$];
    logic [31:0]       exp_rdata;
    bit                exp_err;
    int                base;

    base = int'(addr[ADDR_W-1:0]);
    n    = (sz == 2'b11) ? 0 : (1 << sz);
    if (sz == 2'b11) begin
      exp_err = 1'b1; exp_rdata = 32'h0; exp_lat = 1; exp_beats = 0;
    end else if (never) begin
      exp_err = 1'b1; exp_rdata = 32'h0; exp_lat = TIMEOUT + 1; exp_beats = 0;
    end else begin
      exp_err   = 1'b0;
      exp_rdata = wr ? 32'h0 : model_load(base, sz, uns);
      exp_lat   = n * (delay + 1) + 1;
      exp_beats = n;
    end

    @(negedge clk);
    ack_delay = delay;
    ack_never = never;
    checkOutput("idle_ready", req_ready, 1);
    checkOutput("idle_no_resp", resp_valid, 0);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;

    cycles = 0; got = 0; v_ready = 0; v_both = 0; v_hold = 0; v_dir = 0; waiting = 0;
    prev_addr = '0;
    while (!got && cycles < 200) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      if (resp_valid) begin
        got = 1;
      end else begin
        if (req_ready) v_ready = 1;
        if (mem_re && mem_we) v_both = 1;
        if ((mem_re || mem_we) && (mem_we != wr)) v_dir = 1;
        if (waiting && (!(mem_re || mem_we) || mem_addr != prev_addr)) v_hold = 1;
        if ((mem_re || mem_we) && mem_ack) beats.push_back(mem_addr);
        waiting   = (mem_re || mem_we) && !mem_ack && !never;
        prev_addr = mem_addr;
      end
    end

    checkOutput("resp_seen", got, 1);
    checkOutput("latency", cycles, exp_lat);
    checkOutput("resp_err", resp_err, exp_err);
    checkOutput("resp_rdata", resp_rdata, exp_rdata);
    checkOutput("resp_strobes", {mem_re, mem_we}, 0);
    checkOutput("resp_ready_low", req_ready, 0);
    checkOutput("busy_ready_low", v_ready, 0);
    checkOutput("strobe_excl", v_both, 0);
    checkOutput("strobe_dir", v_dir, 0);
    checkOutput("strobe_hold", v_hold, 0);
    checkOutput("beat_count", beats.size(), exp_beats);
    for (int k = 0; k < beats.size() && k < exp_beats; k++)
      checkOutput("beat_addr", beats[k], (base + k) % DEPTH);

    if (wr && !exp_err)
      for (int k = 0; k < n; k++) ref_mem[(base + k) % DEPTH] = 8'((wdata >> (8 * k)) & 32'hFF);
    for (int k = 0; k < n; k++)
      checkOutput("mem_byte", dut_mem[(base + k) % DEPTH], ref_mem[(base + k) % DEPTH]);

    last_rdata = resp_rdata;
    last_err   = resp_err;
    last_lat   = cycles;
  endtask

  initial begin
    bit v_resp;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'($urandom_range(0, 255));
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_resp_rdata", resp_rdata, 0);
    checkOutput("rst_strobes", {mem_re, mem_we}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    $display("[TB] store/load word");
    applyStimulus(1, 2'b10, 0, 32'd4, 32'hDEADBEEF, 0, 0);
    checkOutput("sw_b4", dut_mem[4], 8'hEF);
    checkOutput("sw_b5", dut_mem[5], 8'hBE);
    checkOutput("sw_b6", dut_mem[6], 8'hAD);
    checkOutput("sw_b7", dut_mem[7], 8'hDE);
    applyStimulus(0, 2'b10, 0, 32'd4, 32'h0, 0, 0);
    checkOutput("lw_value", last_rdata, 32'hDEADBEEF);
    checkOutput("lw_lat", last_lat, 5);

    $display("[TB] sign and zero extension");
    applyStimulus(1, 2'b00, 0, 32'd9, 32'h12345680, 0, 0);
    applyStimulus(1, 2'b01, 0, 32'd10, 32'h5555F234, 0, 0);
    applyStimulus(0, 2'b00, 0, 32'd9, 32'h0, 0, 0);
    checkOutput("lb", last_rdata, 32'hFFFFFF80);
    applyStimulus(0, 2'b00, 1, 32'd9, 32'h0, 0, 0);
    checkOutput("lbu", last_rdata, 32'h00000080);
    applyStimulus(0, 2'b01, 0, 32'd10, 32'h0, 0, 0);
    checkOutput("lh", last_rdata, 32'hFFFFF234);
    applyStimulus(0, 2'b01, 1, 32'd10, 32'h0, 0, 0);
    checkOutput("lhu", last_rdata, 32'h0000F234);

    $display("[TB] wrap, slow memory, timeout, illegal size");
    applyStimulus(0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, 0, 0);
    applyStimulus(1, 2'b01, 0, 32'd20, 32'h0000ABCD, 3, 0);
    checkOutput("slow_sh_lat", last_lat, 9);
    applyStimulus(0, 2'b10, 0, 32'd12, 32'h0, 0, 1);
    checkOutput("timeout_err", last_err, 1);
    applyStimulus(1, 2'b11, 0, 32'd8, 32'hFFFFFFFF, 0, 0);
    checkOutput("illegal_lat", last_lat, 1);

    $display("[TB] reset during second beat");
    @(negedge clk);
    ack_delay = 2; ack_never = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd30; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("rst_pre_re", mem_re, 1);
    checkOutput("rst_pre_addr", mem_addr, 31);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_strobes", {mem_re, mem_we}, 0);
    checkOutput("rst_mid_ready", req_ready, 1);
    v_resp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) v_resp = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) v_resp = 1;
    end
    checkOutput("rst_no_resp", v_resp, 0);
    applyStimulus(0, 2'b00, 0, 32'd30, 32'h0, 0, 0);

    $display("[TB] random traffic");
    for (int t = 0; t < 60; t++) begin
      applyStimulus(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), $urandom(), $urandom(),
                    $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: accepts a load or store request from the pipeline and performs it on a byte-wide, little-endian data memory port, one byte per handshake.
- Covers lb/lbu/lh/lhu/lw/sb/sh/sw. Assembles and sign- or zero-extends load data, splits store data into bytes, and returns a single response per request.
- Sits between the execute/memory stage and the byte-array data memory. Unaligned addresses are legal.

Parameters:
- ADDR_W, 6, width of the memory byte address (64-byte memory); addresses wrap modulo 2^ADDR_W.
- TIMEOUT, 15, maximum cycles to wait for mem_ack on one byte before aborting; must be ≥1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend the load (lbu/lhu); ignored for word and for stores.
- req_addr  in  32  byte address; only [ADDR_W-1:0] is used.
- req_wdata  in  32  store data; byte i is req_wdata[8i+7:8i].
- resp_valid  out  1  one-cycle pulse marking request completion.
- resp_rdata  out  32  load result; 0 for stores and on error.
- resp_err  out  1  valid with resp_valid; 1 = illegal size or timeout.
- mem_addr  out  ADDR_W  byte address for the current beat.
- mem_re  out  1  byte read strobe.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  byte to be written.
- mem_rdata  in  8  read byte, valid when mem_ack=1.
- mem_ack  in  1  memory completed the current beat (may be combinational, same cycle as strobe).

Behaviour:
- Reset (async, Rst_n=0): state IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal beat counter, timeout counter and data registers cleared.
- States: IDLE, BEAT, RESP.
- IDLE: req_ready=1. On req_valid, latch write, size, unsigned, addr, wdata; clear beat index i and the data register.
  - req_size=11: go to RESP with err=1.
  - Otherwise go to BEAT with N = 1, 2 or 4.
- BEAT: req_ready=0. Drive the strobes:
  - mem_re = !write, mem_we = write.
  - mem_addr = (addr + i) mod 2^ADDR_W.
  - mem_wdata = wdata byte i.
  - Strobes stay high until mem_ack.
- On mem_ack in BEAT:
  - For a load, capture mem_rdata into data byte i.
  - Clear the timeout counter.
  - If i = N-1, go to RESP; else i = i+1 and stay in BEAT (no idle cycle between beats).
- Timeout:
  - Counter increments each BEAT cycle without mem_ack.
  - When it reaches TIMEOUT with no ack: drop strobes, go to RESP with err=1. Partial store bytes already written are not rolled back.
- RESP: resp_valid=1 for exactly one cycle, strobes 0, req_ready=0, then return to IDLE.
  - resp_rdata/resp_err are registered and held until the next RESP; they are only meaningful while resp_valid=1.
- Load extension (word: no extension):
  - byte: bits [31:8] = unsigned ? 0 : {24{b0[7]}}.
  - half: bits [31:16] = unsigned ? 0 : {16{b1[7]}}.
- Latency: request accepted in cycle T (a request on req_valid is taken in any cycle the unit is in IDLE).
  - With mem_ack tied 1: beats occur in T+1..T+N, and resp_valid is in T+N+1.
  - Illegal size: resp_valid in T+1, no strobes.
  - Back-to-back: the next request can be accepted in the cycle after RESP.
- Address wrap: a beat at 2^ADDR_W-1 is followed by a beat at 0.
- mem_ack outside BEAT is ignored. mem_re and mem_we are never both 1.
- Reset mid-operation: strobes drop asynchronously, no response is issued, and the request is lost.

Test Plan:
- Store then load word: sw addr=4, wdata=0xDEADBEEF (mem_ack=1).
  - Writes at 4..7 must be EF, BE, AD, DE.
  - A following lw at 4 must give resp_rdata=0xDEADBEEF at T+5, resp_err=0.
- Sign and zero extension with byte 0x80 at addr 9 and bytes 34, F2 at 10..11:
  - lb 9 -> 0xFFFFFF80; lbu 9 -> 0x00000080.
  - lh 10 -> 0xFFFFF234; lhu 10 -> 0x0000F234.
- Unaligned wrap: lw at addr=62 with ADDR_W=6 -> mem_addr sequence 62, 63, 0, 1; result assembled little-endian from those bytes.
- Slow memory: mem_ack delayed 3 cycles per beat on an sh.
  - Strobes and mem_addr are held steady while waiting.
  - resp_valid arrives after 2×4 beat cycles.
  - req_ready stays 0 throughout.
- Timeout and illegal size:
  - mem_ack held 0 on lw -> after TIMEOUT cycles, resp_valid=1, resp_err=1, resp_rdata=0.
  - req_size=11 -> resp_valid at T+1 with err=1 and no strobe.
- Reset mid-operation: Rst_n asserted during beat 2 of lw.
  - Strobes go 0 immediately; no resp_valid.
  - After release, req_ready=1 and a new lb completes normally.
